ram_dma_ci_engine: RTL
======================

# ram_dma_ci_engine

Parametrised custom-instruction scratch buffer with an integrated single-channel DMA engine. The CPU reaches the dual-port buffer and the DMA control registers through the custom-instruction interface. The DMA engine moves blocks of 32-bit words between the buffer and system memory over a simple single-beat memory master port. It sits beside the CPU as a custom-instruction unit and as an extra master on the memory arbiter.

## Interface
- CUSTOM_ID, 8'h00, ciN value this unit responds to
- ADDR_W, 9, buffer address width; depth = 2^ADDR_W words; legal range 4..12
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  custom-instruction start strobe
- ciN  in  8  custom-instruction number
- valueA  in  32  command word: [15:13] function, [12] write, [11:0] address (upper bits beyond ADDR_W ignored)
- valueB  in  32  write data
- done  out  1  one-cycle completion pulse
- result  out  32  read data, held until next completion
- memReq  out  1  DMA request, held until memAck or memErr
- memWe  out  1  1 = write to memory
- memAddr  out  32  byte address, bits [1:0] always 0
- memWdata  out  32  write data
- memRdata  in  32  read data, valid with memAck
- memAck  in  1  transfer accepted/completed
- memErr  in  1  bus error, replaces memAck
- irq  out  1  transfer-complete interrupt (only with RAM_DMA_CI_IRQ_EN)

## Operation
- A command is accepted only when start=1, ciN==CUSTOM_ID, and valueA[31:16]==0. Any other start with a matching ciN pulses done with result=0 and takes no action.
- fn 0, buffer: write stores valueB at buf[addr]. Read returns buf[addr].
- fn 1, BUS_ADDR: write takes valueB with [1:0] cleared. Read returns the register.
- fn 2, BUF_ADDR: write takes valueB[ADDR_W-1:0]. Read returns it zero-extended.
- fn 3, BLOCK_SIZE: write takes valueB[ADDR_W:0], in words. Read returns it zero-extended.
- fn 4, CTRL/STATUS:
  - Write: bit0 = go, bit1 = direction (0 memory->buffer, 1 buffer->memory).
  - Read: bit0 busy, bit1 error, bit2 direction; also clears irq.
- fn 5..7: not used; done pulses with result=0.
- Writes to fn 1..4 while busy are ignored. Done still pulses.
- A go with BLOCK_SIZE=0 completes immediately: busy stays 0, error is cleared, irq is set if enabled.
- DMA FSM states: IDLE, FETCH, XFER, ERROR.
  - IDLE + go: load working counters, clear error, set busy. Next state is XFER for direction 0, FETCH for direction 1.
  - FETCH (direction 1 only): read buf[idx] on port B. Next state XFER.
  - XFER: memReq=1.
    - On memAck, direction 0: write memRdata to buf[idx].
    - On memAck, both directions: idx+1 mod depth, addr+4 mod 2^32, count-1. If count reaches 0, go to IDLE. Otherwise go to XFER (direction 0) or FETCH (direction 1).
    - On memErr: go to ERROR.
  - ERROR: set error, clear busy, go to IDLE.
- Idle clears busy. Any exit from the DMA sets irq.
- Programmed registers are never modified by the DMA; working copies are used.
- Same-cycle CPU write and DMA write to the same buffer word: the CPU value is stored.

## Timing
- Reset values: done 0, result 0, memReq 0, memWe 0, memAddr 0, memWdata 0, irq 0. All registers are 0, FSM is IDLE.
- Reset mid-transfer aborts; memReq deasserts asynchronously.
- Latency, counted from the cycle after start:
  - Buffer write and register access: done in cycle +1.
  - Buffer read: done in cycle +2.
- memReq, memWe, memAddr and memWdata are stable while memReq=1. memReq drops in the cycle after memAck or memErr.
- Throughput:
  - Direction 0: one word per cycle with memAck tied high.
  - Direction 1: one word per 2 cycles.
- The first memReq appears 1 cycle (direction 0) or 2 cycles (direction 1) after the go command is accepted.
- A new CI start before the previous done is not supported.

## Configuration
- RAM_DMA_CI_IRQ_EN defined:
  - The irq port exists.
  - irq is set on the cycle the DMA returns to IDLE (completion or error).
  - irq is cleared by a status read; a same-cycle set wins.
- Not defined: no irq port and no irq logic. Software polls the busy bit.

## Structure
- Package ram_dma_ci_pkg holds:
  - function codes FN_BUF..FN_CTRL;
  - the DMA state enum;
  - status bit positions (STAT_BUSY, STAT_ERR, STAT_DIR);
  - the valueA field positions.
- Sub-module dp_ssram(ADDR_W, 32): true dual-port synchronous RAM, 1-cycle read latency. Port A is the CPU, port B the DMA.

## Test plan
- Buffer write 0xDEADBEEF to addr 5, then read addr 5: done at +1 for the write, result 0xDEADBEEF with done at +2 for the read.
- Memory->buffer, BUS_ADDR 0x1000, BUF_ADDR 0x1FE, BLOCK_SIZE 4, ack every cycle, memory word i = 0x100+i:
  - buffer words 0x1FE, 0x1FF, 0x000, 0x001 hold 0x100..0x103 (index wrap);
  - memAddr sequence 0x1000..0x100C;
  - status reads 0 afterwards.
- Buffer->memory, 3 words, memAck delayed 2 cycles per beat: memWe=1, memWdata matches the buffer, memReq held stable until each ack.
- memErr on beat 2 of 4: memReq drops, status reads 0x2, irq=1 (with the macro), and the next go clears the error.
- Go with BLOCK_SIZE=0: no memReq, status 0. A BUS_ADDR write while busy leaves the register unchanged.
- Reset asserted mid-transfer: memReq=0 immediately, status 0; start with valueA[20]=1 gives done with result 0.

Source files
------------

// File: rtl/ram_dma_ci_pkg.sv
// ram_dma_ci_pkg
// Shared definitions for the custom-instruction scratch buffer with DMA:
//   - function codes carried in valueA[15:13]
//   - DMA state encoding
//   - CTRL write bits and STATUS read bits
//   - valueA field positions
package ram_dma_ci_pkg;

  // Function codes
  localparam logic [2:0] FN_BUF        = 3'd0;
  localparam logic [2:0] FN_BUS_ADDR   = 3'd1;
  localparam logic [2:0] FN_BUF_ADDR   = 3'd2;
  localparam logic [2:0] FN_BLOCK_SIZE = 3'd3;
  localparam logic [2:0] FN_CTRL       = 3'd4;

  // DMA engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_XFER  = 2'd2,
    ST_ERROR = 2'd3
  } dma_state_t;

  // STATUS read bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_ERR  = 1;
  localparam int STAT_DIR  = 2;

  // CTRL write bit positions
  localparam int CTRL_GO  = 0;
  localparam int CTRL_DIR = 1;

  // valueA command word fields
  localparam int VA_FN_HI   = 15;
  localparam int VA_FN_LO   = 13;
  localparam int VA_WR      = 12;
  localparam int VA_ADDR_HI = 11;
  localparam int VA_RSVD_LO = 16;

endpackage

// File: rtl/ram_dma_ci_engine_dp_ssram.sv
// dp_ssram
// True dual-port synchronous RAM with one cycle of read latency on each port.
// Port A belongs to the CPU and port B to the DMA engine.
//
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//                         (reset clears only the read-data registers)
//   a_en, a_we, a_addr    port A enable, write enable and address
//   a_wdata, a_rdata      port A write data and registered read data
//   b_en, b_we, b_addr    port B enable, write enable and address
//   b_wdata, b_rdata      port B write data and registered read data
//
// When both ports write the same word in one cycle, port A's value is kept.
// A read returns the word as it was before any write in that cycle.
// Each read-data register holds its value until that port reads again.
module dp_ssram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Port A is written second, so port A wins a same-word collision.
  always_ff @(posedge clock) begin
    if (b_en && b_we) mem[b_addr] <= b_wdata;
    if (a_en && a_we) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_en && !a_we) a_rdata <= mem[a_addr];
      if (b_en && !b_we) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/ram_dma_ci_engine.sv
// ram_dma_ci_engine
// Custom-instruction scratch buffer with a single-channel DMA engine.
// The CPU reaches the buffer (port A) and the DMA registers through the
// custom-instruction interface. The DMA moves blocks of 32-bit words between
// the buffer (port B) and system memory over a single-beat master port.
//
// Optional feature: define RAM_DMA_CI_IRQ_EN to add the irq port and its logic.
//
// Ports:
//   clock, reset                  clock and asynchronous active-high reset
//   start, ciN, valueA, valueB    custom-instruction request
//   done, result                  completion pulse and read data
//   memReq, memWe, memAddr,
//   memWdata                      memory master request
//   memRdata, memAck, memErr      memory master response
//   dbg_state                     current DMA state, for debug visibility
//   irq                           transfer-complete interrupt (RAM_DMA_CI_IRQ_EN only)
//
// Memory handshake: memReq rises with memAddr, memWe and memWdata valid.
// All four stay stable until the cycle in which memAck or memErr is high.
// That cycle completes the beat, and memErr takes priority over memAck.
// In the memory-to-buffer direction the next beat's request can follow
// back to back.
module ram_dma_ci_engine
  import ram_dma_ci_pkg::*;
#(
  parameter logic [7:0] CUSTOM_ID = 8'h00,
  parameter int         ADDR_W    = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  input  logic        memAck,
  input  logic        memErr,
  output logic [1:0]  dbg_state
`ifdef RAM_DMA_CI_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

  dma_state_t        state;
  logic              busy, error, dir_reg, w_dir, mem_req, rd_pend;
  logic [31:0]       bus_addr, w_addr;
  logic [ADDR_W-1:0] buf_addr, w_idx;
  logic [ADDR_W:0]   block_size, w_count;
  logic [31:0]       a_rdata, b_rdata, status_word;

  // Command decode
  logic              ci_hit, cmd_ok, cmd_wr, reg_wr_ok, go_cmd;
  logic [2:0]        cmd_fn;
  logic [ADDR_W-1:0] cmd_addr;
  logic              unused_bits;

  assign ci_hit    = start && (ciN == CUSTOM_ID);
  assign cmd_ok    = ci_hit && (valueA[31:VA_RSVD_LO] == 16'h0);
  assign cmd_fn    = valueA[VA_FN_HI:VA_FN_LO];
  assign cmd_wr    = valueA[VA_WR];
  assign cmd_addr  = valueA[ADDR_W-1:0];
  // Register writes are dropped while a transfer is in flight.
  assign reg_wr_ok = cmd_ok && cmd_wr && !busy;
  assign go_cmd    = reg_wr_ok && (cmd_fn == FN_CTRL) && valueB[CTRL_GO];
  // Address bits above ADDR_W are ignored.
  assign unused_bits = &{1'b0, valueA[VA_ADDR_HI:0]};

  always_comb begin
    status_word            = '0;
    status_word[STAT_BUSY] = busy;
    status_word[STAT_ERR]  = error;
    status_word[STAT_DIR]  = dir_reg;
  end

  // Buffer: port A is the CPU, port B is the DMA
  logic buf_a_en, buf_a_we, buf_b_en, buf_b_we;

  assign buf_a_en = cmd_ok && (cmd_fn == FN_BUF);
  assign buf_a_we = buf_a_en && cmd_wr;
  assign buf_b_en = (state == ST_FETCH) || buf_b_we;
  assign buf_b_we = (state == ST_XFER) && memAck && !memErr && !w_dir;

  dp_ssram #(.ADDR_W(ADDR_W), .DATA_W(32)) u_buf (
    .clock   (clock),
    .reset   (reset),
    .a_en    (buf_a_en),
    .a_we    (buf_a_we),
    .a_addr  (cmd_addr),
    .a_wdata (valueB),
    .a_rdata (a_rdata),
    .b_en    (buf_b_en),
    .b_we    (buf_b_we),
    .b_addr  (w_idx),
    .b_wdata (memRdata),
    .b_rdata (b_rdata)
  );

  // CPU side: programmed registers and completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done       <= 1'b0;
      result     <= '0;
      rd_pend    <= 1'b0;
      bus_addr   <= '0;
      buf_addr   <= '0;
      block_size <= '0;
      dir_reg    <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= 1'b0;
      // Buffer reads complete one cycle later, once the RAM data is out.
      if (rd_pend) begin
        done   <= 1'b1;
        result <= a_rdata;
      end
      if (ci_hit) begin
        if (!cmd_ok) begin
          done   <= 1'b1;
          result <= '0;
        end else begin
          case (cmd_fn)
            FN_BUF: begin
              if (cmd_wr) begin
                done   <= 1'b1;
                result <= '0;
              end else begin
                rd_pend <= 1'b1;
              end
            end
            FN_BUS_ADDR: begin
              done   <= 1'b1;
              result <= cmd_wr ? 32'd0 : bus_addr;
              if (reg_wr_ok) bus_addr <= {valueB[31:2], 2'b00};
            end
            FN_BUF_ADDR: begin
              done   <= 1'b1;
              result <= cmd_wr ? 32'd0 : 32'(buf_addr);
              if (reg_wr_ok) buf_addr <= valueB[ADDR_W-1:0];
            end
            FN_BLOCK_SIZE: begin
              done   <= 1'b1;
              result <= cmd_wr ? 32'd0 : 32'(block_size);
              if (reg_wr_ok) block_size <= valueB[ADDR_W:0];
            end
            FN_CTRL: begin
              done   <= 1'b1;
              result <= cmd_wr ? 32'd0 : status_word;
              if (reg_wr_ok) dir_reg <= valueB[CTRL_DIR];
            end
            default: begin
              done   <= 1'b1;
              result <= '0;
            end
          endcase
        end
      end
    end
  end

  // DMA engine. It works on copies of the programmed registers, so software
  // can read back what it programmed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      error   <= 1'b0;
      w_dir   <= 1'b0;
      w_idx   <= '0;
      w_addr  <= '0;
      w_count <= '0;
      mem_req <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (go_cmd) begin
            w_idx   <= buf_addr;
            w_addr  <= bus_addr;
            w_count <= block_size;
            w_dir   <= valueB[CTRL_DIR];
            error   <= 1'b0;
            // A zero-length block finishes without leaving IDLE.
            if (block_size != '0) begin
              busy    <= 1'b1;
              mem_req <= !valueB[CTRL_DIR];
              state   <= valueB[CTRL_DIR] ? ST_FETCH : ST_XFER;
            end
          end
        end
        ST_FETCH: begin
          // The buffer word appears on b_rdata, which drives memWdata.
          mem_req <= 1'b1;
          state   <= ST_XFER;
        end
        ST_XFER: begin
          if (memErr) begin
            mem_req <= 1'b0;
            state   <= ST_ERROR;
          end else if (memAck) begin
            w_idx   <= w_idx + IDX_ONE;
            w_addr  <= w_addr + 32'd4;
            w_count <= w_count - CNT_ONE;
            if (w_count == CNT_ONE) begin
              mem_req <= 1'b0;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end else if (w_dir) begin
              mem_req <= 1'b0;
              state   <= ST_FETCH;
            end
          end
        end
        ST_ERROR: begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign memReq    = mem_req;
  assign memWe     = w_dir;
  assign memAddr   = w_addr;
  assign memWdata  = b_rdata;
  assign dbg_state = state;

`ifdef RAM_DMA_CI_IRQ_EN
  logic stat_rd, dma_exit;

  assign stat_rd  = cmd_ok && !cmd_wr && (cmd_fn == FN_CTRL);
  assign dma_exit = (state == ST_ERROR)
                 || ((state == ST_XFER) && memAck && !memErr && (w_count == CNT_ONE))
                 || (go_cmd && (block_size == '0));

  // A status read clears the interrupt, but a set in the same cycle wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)         irq <= 1'b0;
    else if (dma_exit) irq <= 1'b1;
    else if (stat_rd)  irq <= 1'b0;
  end
`endif

endmodule
